multi_cycle_mod_reducer: RTL and testbench
==========================================

# multi_cycle_mod_reducer

Pipelined final-reduction stage placed directly downstream of `multi_cycle_adder` in the BN254 Fp datapath. It takes the raw sum `Z = X + Y` of two reduced operands, where `0 <= Z < 2P`, and returns `Z mod P` by a multi-cycle conditional subtraction of the modulus. The borrow ripples one limb per cycle, so no single path carries the full-width subtract. The block is fully pipelined (one result per cycle) with a valid/tag sideband and a global stall enable.

## Interface
- `LATENCY`, default 3: number of limb stages, which equals the cycle latency. Must be >= 1.
- `TAG_W`, default 8: width of the opaque tag carried alongside each operand.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: pipeline enable. When low, every register holds its value.
- `valid_i`  in  1: `Z_i` and `tag_i` are valid this cycle.
- `Z_i`  in  `uint_fp_t`: unreduced sum, `0 <= Z_i < 2P`.
- `tag_i`  in  `TAG_W`: sideband, passed through unchanged.
- `valid_o`  out  1: `Z_o` and `tag_o` are valid.
- `Z_o`  out  `uint_fp_t`: `Z_i mod P`, always `< P`.
- `tag_o`  out  `TAG_W`: tag of the result on `Z_o`.

## Operation
- `N = $bits(uint_fp_t)`. The width requirement `2P < 2^N` holds for the package constant `P`.
- `Z_i` is split into `LATENCY` limbs of width `L = ceil(N/LATENCY)`. The top limb takes the remainder width `N - (LATENCY-1)*L`.
- Stage `k` (`k = 0..LATENCY-1`):
  - computes limb k of `Z - P` using the borrow registered by stage `k-1`; stage 0 uses borrow-in 0;
  - registers the diff limb and the new borrow.
- Each stage also forwards the untouched full `Z`, the diff limbs completed so far, `valid` and `tag`.
- Final stage: the top-limb borrow-out is the select.
  - Borrow = 1 (`Z < P`): `Z_o = Z`.
  - Borrow = 0 (`Z >= P`): `Z_o = Z - P`.
  - The selection is combinational into the output register, so the output is registered.
- Data registers load regardless of `valid`. Bubbles propagate with `valid = 0`, and their data content is don't-care.
- `en = 0` freezes every stage, including the `valid`, `tag` and data registers. No entries are dropped or duplicated.
- Inputs with `Z_i >= 2P` are illegal. The output for them is unspecified, but the pipeline must not lock up.

## Timing
- Latency is exactly `LATENCY` enabled cycles from the `valid_i` sample to `valid_o`. Initiation interval is 1.
- A sample at enabled edge t appears at `Z_o` after enabled edge t+LATENCY-1 (t counted from 0). With `en = 1` throughout, that is `LATENCY` clock edges.
- Reset values:
  - `valid_o = 0`, `Z_o = 0`, `tag_o = 0`;
  - all internal valid, borrow and data registers = 0.
- Reset asserted mid-stream discards all in-flight entries immediately and asynchronously. The first `valid_o` after release comes no earlier than `LATENCY` enabled cycles after the first new `valid_i`.
- `rst` has priority over `en`.
- `en` low on the same edge as `valid_i` high: the input is not sampled. The upstream stage must hold it.
- No backpressure output. Upstream stalls with the same `en`.

## Structure
- Shared package `PARAMS_BN254_d0` provides `uint_fp_t` and modulus `P`. These are not redefined locally.
- Constant `L`, limb index ranges and the top-limb width are localparams derived from `N` and `LATENCY`.
- Sub-module `mcr_limb_sub`:
  - one limb subtractor: `a - b - borrow_in` yielding diff and borrow_out;
  - instantiated `LATENCY` times in a generate loop with per-instance width.
- Stage registers live in the top module. The stage payload is a packed struct: `valid`, `tag`, `Z`, diff so far, `borrow`.

## Test plan
- Boundary values, `LATENCY=3`, `en=1`:
  - `Z_i=0` -> `Z_o=0`
  - `Z_i=P-1` -> `Z_o=P-1`
  - `Z_i=P` -> `Z_o=0`
  - `Z_i=2P-1` -> `Z_o=P-1`
  - Each result arrives exactly 3 cycles later with its tag.
- Limb-boundary borrow: `Z_i = P + 2^L - 1` and `Z_i = P - 2^L` -> `Z_o = 2^L - 1` and `Z_o = P - 2^L` respectively. Run for `LATENCY` = 1, 2, 3, 5.
- Streaming: 10^6 back-to-back random `X,Y < P`, with `Z_i = X+Y` and `tag_i` = index mod 256.
  - Every `Z_o == (X+Y) mod P`.
  - Tags arrive in order.
  - `valid_o` stays high continuously after fill.
- Stall: random `en` low 30% of cycles with a continuous valid stream.
  - Results and tags match a reference queue.
  - No drop or duplicate.
  - Latency counted in enabled cycles is `LATENCY`.
- Bubbles: `valid_i` pattern 1,0,0,1,1,0 -> the identical pattern on `valid_o`, shifted by `LATENCY`.
- Reset: assert `rst` for 1 cycle while 3 entries are in flight, asynchronously mid-cycle.
  - `valid_o`, `Z_o` and `tag_o` go to 0 before the next edge.
  - No stale entry ever emerges.
  - A new input after release returns correctly after `LATENCY` cycles.

Source files
------------

// File: rtl/multi_cycle_mod_reducer_pkg.sv
// BN254 field parameters plus the limb-geometry helpers used by the
// multi-cycle final-reduction stage.
package PARAMS_BN254_d0;
    typedef logic [255:0] uint_fp_t;
    localparam uint_fp_t P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
endpackage

package multi_cycle_mod_reducer_pkg;
    import PARAMS_BN254_d0::*;

    localparam int FP_W = $bits(uint_fp_t);

    // Every limb is ceil(n/stages) wide except the top one, which takes what is left.
    function automatic int limb_width(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    function automatic int top_limb_width(input int n, input int stages);
        return n - (stages - 1) * limb_width(n, stages);
    endfunction
endpackage

// File: rtl/multi_cycle_mod_reducer_limb_sub.sv
// One limb of the rippled Z - P subtraction: a - b - borrow_in.
module mcr_limb_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] full_w;

    // The extra top bit goes to 1 exactly when the limb result is negative.
    assign full_w = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
    assign {borrow_o, diff_o} = full_w;

endmodule

// File: rtl/multi_cycle_mod_reducer.sv
// Pipelined Z mod P for 0 <= Z < 2P: one limb of Z - P per stage, borrow
// carried between stages, final borrow selects Z or Z - P into the output register.
module multi_cycle_mod_reducer
    import PARAMS_BN254_d0::*;
    import multi_cycle_mod_reducer_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_i,
    input  uint_fp_t         Z_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output uint_fp_t         Z_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int N     = FP_W;
    localparam int L     = limb_width(N, LATENCY);
    localparam int TOP_W = top_limb_width(N, LATENCY);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        uint_fp_t         z;
        uint_fp_t         diff;
        logic             borrow;
    } stage_t;

    stage_t stage_out [LATENCY];

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        localparam int LO = k * L;
        localparam int W  = (k == LATENCY - 1) ? TOP_W : L;

        stage_t     in_w;
        stage_t     stage_d;
        stage_t     stage_q;
        logic [W-1:0] diff_limb;
        logic         borrow_out;

        if (k == 0) begin : g_head
            assign in_w = '{valid: valid_i, tag: tag_i, z: Z_i, diff: '0, borrow: 1'b0};
        end else begin : g_body
            assign in_w = stage_out[k-1];
        end

        mcr_limb_sub #(
            .W(W)
        ) u_limb_sub (
            .a_i      (in_w.z[LO +: W]),
            .b_i      (P[LO +: W]),
            .borrow_i (in_w.borrow),
            .diff_o   (diff_limb),
            .borrow_o (borrow_out)
        );

        // The last stage turns its borrow into the select; earlier stages just accumulate limbs.
        always_comb begin
            stage_d = in_w;
            stage_d.diff[LO +: W] = diff_limb;
            stage_d.borrow = borrow_out;
            if (k == LATENCY - 1) begin
                stage_d.z = borrow_out ? in_w.z : stage_d.diff;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else if (en) begin
                stage_q <= stage_d;
            end
        end

        assign stage_out[k] = stage_q;
    end

    assign valid_o = stage_out[LATENCY-1].valid;
    assign Z_o     = stage_out[LATENCY-1].z;
    assign tag_o   = stage_out[LATENCY-1].tag;

endmodule

// File: tb/tb_multi_cycle_mod_reducer.sv
// Directed bench for multi_cycle_mod_reducer; the LATENCY=3 instance is the main
// target, the 1/2/5 instances share the same inputs for the limb-boundary vectors.
module tb_multi_cycle_mod_reducer;

    localparam logic [255:0] PMOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic         clk;
    logic         rst;
    logic         en;
    logic         valid_i;
    logic [255:0] Z_i;
    logic [7:0]   tag_i;

    logic         v1, v2, v3, v5;
    logic [255:0] z1, z2, z3, z5;
    logic [7:0]   t1, t2, t3, t5;

    int compared   = 0;
    int mismatched = 0;

    multi_cycle_mod_reducer #(.LATENCY(1), .TAG_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .Z_i(Z_i), .tag_i(tag_i),
        .valid_o(v1), .Z_o(z1), .tag_o(t1));
    multi_cycle_mod_reducer #(.LATENCY(2), .TAG_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .Z_i(Z_i), .tag_i(tag_i),
        .valid_o(v2), .Z_o(z2), .tag_o(t2));
    multi_cycle_mod_reducer #(.LATENCY(3), .TAG_W(8)) dut3 (
        .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .Z_i(Z_i), .tag_i(tag_i),
        .valid_o(v3), .Z_o(z3), .tag_o(t3));
    multi_cycle_mod_reducer #(.LATENCY(5), .TAG_W(8)) dut5 (
        .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .Z_i(Z_i), .tag_i(tag_i),
        .valid_o(v5), .Z_o(z5), .tag_o(t5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] randFp();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        r[255:254] = 2'b00;
        if (r >= PMOD) r = r - PMOD;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; valid_i = 1'b0; Z_i = '0; tag_i = '0;
        #2;
        compared++;
        if (v3 !== 1'b0 || z3 !== '0 || t3 !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_lat3: got valid=%0b Z=%h tag=%h, want all 0", v3, z3, t3);
        end
        compared++;
        if ({v1, v2, v5} !== 3'b000 || z1 !== '0 || z2 !== '0 || z5 !== '0 ||
            t1 !== '0 || t2 !== '0 || t5 !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_other: got valid=%b%b%b, want 000 with zero data", v1, v2, v5);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_boundary();
        logic [255:0] bz [4];
        logic [255:0] be [4];
        int idx;
        bz[0] = '0;          be[0] = '0;
        bz[1] = PMOD - 1;    be[1] = PMOD - 1;
        bz[2] = PMOD;        be[2] = '0;
        bz[3] = 2*PMOD - 1;  be[3] = PMOD - 1;
        en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                valid_i = 1'b1; Z_i = bz[c]; tag_i = 8'h10 + 8'(c);
            end else begin
                valid_i = 1'b0;
            end
            tick();
            idx = c - 2;
            compared++;
            if (idx >= 0 && idx < 4) begin
                if (v3 !== 1'b1 || z3 !== be[idx] || t3 !== 8'h10 + 8'(idx)) begin
                    mismatched++;
                    $display("[TB] FAIL boundary[%0d]: got valid=%0b Z=%h tag=%h, want 1 Z=%h tag=%h",
                             idx, v3, z3, t3, be[idx], 8'h10 + 8'(idx));
                end
            end else if (v3 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL boundary_idle cycle %0d: got valid=%0b, want 0", c, v3);
            end
        end
    endtask

    task automatic test_limb_boundary();
        int           lat [9];
        logic [255:0] vz  [9];
        logic [255:0] ve  [9];
        logic         ov;
        logic [255:0] oz;
        logic [7:0]   ot;
        lat[0] = 1; vz[0] = PMOD;                          ve[0] = '0;
        lat[1] = 1; vz[1] = 2*PMOD - 1;                    ve[1] = PMOD - 1;
        lat[2] = 1; vz[2] = PMOD - 1;                      ve[2] = PMOD - 1;
        lat[3] = 2; vz[3] = PMOD + (256'd1 << 128) - 1;    ve[3] = (256'd1 << 128) - 1;
        lat[4] = 2; vz[4] = PMOD - (256'd1 << 128);        ve[4] = PMOD - (256'd1 << 128);
        lat[5] = 3; vz[5] = PMOD + (256'd1 << 86) - 1;     ve[5] = (256'd1 << 86) - 1;
        lat[6] = 3; vz[6] = PMOD - (256'd1 << 86);         ve[6] = PMOD - (256'd1 << 86);
        lat[7] = 5; vz[7] = PMOD + (256'd1 << 52) - 1;     ve[7] = (256'd1 << 52) - 1;
        lat[8] = 5; vz[8] = PMOD - (256'd1 << 52);         ve[8] = PMOD - (256'd1 << 52);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            valid_i = 1'b1; Z_i = vz[i]; tag_i = 8'hA0 + 8'(i);
            for (int k = 1; k <= lat[i]; k++) begin
                tick();
                valid_i = 1'b0;
            end
            case (lat[i])
                1:       begin ov = v1; oz = z1; ot = t1; end
                2:       begin ov = v2; oz = z2; ot = t2; end
                3:       begin ov = v3; oz = z3; ot = t3; end
                default: begin ov = v5; oz = z5; ot = t5; end
            endcase
            compared++;
            if (ov !== 1'b1 || oz !== ve[i] || ot !== 8'hA0 + 8'(i)) begin
                mismatched++;
                $display("[TB] FAIL limb[%0d] lat=%0d: got valid=%0b Z=%h tag=%h, want 1 Z=%h tag=%h",
                         i, lat[i], ov, oz, ot, ve[i], 8'hA0 + 8'(i));
            end
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_back_to_back();
        localparam int NB = 32;
        logic [255:0] sz [NB];
        logic [255:0] se [NB];
        logic [255:0] x, y;
        int idx;
        for (int i = 0; i < NB; i++) begin
            x = randFp(); y = randFp();
            sz[i] = x + y;
            se[i] = (sz[i] >= PMOD) ? sz[i] - PMOD : sz[i];
        end
        sz[0] = 2*PMOD - 2; se[0] = PMOD - 2;
        en = 1'b1;
        for (int c = 0; c < NB + 3; c++) begin
            if (c < NB) begin
                valid_i = 1'b1; Z_i = sz[c]; tag_i = 8'(c);
            end else begin
                valid_i = 1'b0;
            end
            tick();
            idx = c - 2;
            if (idx >= 0 && idx < NB) begin
                compared++;
                if (v3 !== 1'b1 || z3 !== se[idx] || t3 !== 8'(idx)) begin
                    mismatched++;
                    $display("[TB] FAIL stream[%0d]: got valid=%0b Z=%h tag=%h, want 1 Z=%h tag=%h",
                             idx, v3, z3, t3, se[idx], 8'(idx));
                end
            end
        end
    endtask

    typedef struct {
        logic [255:0] z;
        logic [7:0]   tag;
        int           edgeNo;
    } exp_t;

    task automatic test_stall();
        exp_t         q[$];
        exp_t         e;
        logic [255:0] x, y, s, curExp;
        int           total = 60;
        int           sent = 0;
        int           received = 0;
        int           enEdges = 0;
        logic         loadNew = 1'b1;
        curExp = '0;
        for (int c = 0; c < 600 && (sent < total || q.size() > 0); c++) begin
            if (sent < total) begin
                if (loadNew) begin
                    x = randFp(); y = randFp(); s = x + y;
                    Z_i = s; tag_i = 8'(sent);
                    curExp = (s >= PMOD) ? s - PMOD : s;
                    loadNew = 1'b0;
                end
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            en = ($urandom_range(0, 9) >= 3);
            tick();
            if (en) begin
                enEdges++;
                if (valid_i) begin
                    q.push_back('{z: curExp, tag: tag_i, edgeNo: enEdges});
                    sent++;
                    loadNew = 1'b1;
                end
                if (v3) begin
                    compared++;
                    if (q.size() == 0) begin
                        mismatched++;
                        $display("[TB] FAIL stall_extra: got unexpected valid output Z=%h tag=%h, want none", z3, t3);
                    end else begin
                        e = q.pop_front();
                        received++;
                        if (z3 !== e.z || t3 !== e.tag || enEdges - e.edgeNo != 2) begin
                            mismatched++;
                            $display("[TB] FAIL stall_entry: got Z=%h tag=%h lat=%0d, want Z=%h tag=%h lat=2",
                                     z3, t3, enEdges - e.edgeNo, e.z, e.tag);
                        end
                    end
                end
            end
        end
        en = 1'b1;
        valid_i = 1'b0;
        compared++;
        if (received != total || q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_count: got %0d results (%0d pending), want %0d", received, q.size(), total);
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_bubbles();
        bit pat [6];
        int idx;
        logic expV;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                valid_i = pat[c]; Z_i = PMOD + 256'(c); tag_i = 8'h50 + 8'(c);
            end else begin
                valid_i = 1'b0;
            end
            tick();
            idx = c - 2;
            expV = (idx >= 0 && idx < 6) ? pat[idx] : 1'b0;
            compared++;
            if (v3 !== expV || (expV && (z3 !== 256'(idx) || t3 !== 8'h50 + 8'(idx)))) begin
                mismatched++;
                $display("[TB] FAIL bubble cycle %0d: got valid=%0b Z=%h tag=%h, want valid=%0b",
                         c, v3, z3, t3, expV);
            end
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; Z_i = PMOD + 256'(100 + i); tag_i = 8'hC0 + 8'(i);
            tick();
        end
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (v3 !== 1'b0 || z3 !== '0 || t3 !== '0) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got valid=%0b Z=%h tag=%h, want all 0", v3, z3, t3);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (v3 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL midreset_stale cycle %0d: got valid=%0b Z=%h, want 0", c, v3, z3);
            end
        end
        valid_i = 1'b1; Z_i = 2*PMOD - 2; tag_i = 8'h77;
        for (int c = 0; c < 4; c++) begin
            tick();
            valid_i = 1'b0;
            compared++;
            if (c == 2) begin
                if (v3 !== 1'b1 || z3 !== PMOD - 2 || t3 !== 8'h77) begin
                    mismatched++;
                    $display("[TB] FAIL midreset_new: got valid=%0b Z=%h tag=%h, want 1 Z=%h tag=77",
                             v3, z3, t3, PMOD - 2);
                end
            end else if (v3 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL midreset_new_idle cycle %0d: got valid=%0b, want 0", c, v3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_limb_boundary();
        test_back_to_back();
        test_stall();
        test_bubbles();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
